// File: rtl/button_event_ctrl.sv
// button_event_ctrl: services pushbutton PIO interrupts over an Avalon-MM
// master port and queues captured button masks in a small event FIFO.
// Optional post-service lockout: define BUTTON_EVENT_CTRL_LOCKOUT_EN.
module button_event_ctrl #(
  parameter logic [3:0] IRQ_MASK       = 4'hF,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         LOCKOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        pio_irq,
  output logic [3:0]  evt_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    INIT_MASK, INIT_CLR, IDLE, RD_REQ, RD_WAIT, CLR, PUSH, LOCKOUT
  } state_t;

  state_t      state_q, state_d;
  logic        started_q, started_d;
  logic [1:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cap_q, cap_d;
  logic [3:0]  mem_q [FIFO_DEPTH];
  logic [3:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        pop, push, drop, full, in_push;
  logic        unused_bits;

`ifdef BUTTON_EVENT_CTRL_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  assign unused_bits = ^avm_readdata[31:4];
`else
  assign unused_bits = ^{avm_readdata[31:4], (LOCKOUT_CYCLES > 0)};
`endif

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wdata_q;
  assign busy           = (state_q != IDLE);
  assign evt_valid      = (count_q != '0);
  assign evt_data       = mem_q[rd_ptr_q];
  assign overflow       = ovf_q;

  // Next state; the first cycle out of reset holds INIT_MASK so the mask
  // write is actually presented on the bus for one full cycle.
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    if (!started_q) begin
      state_d = INIT_MASK;
    end else begin
      case (state_q)
        INIT_MASK: state_d = INIT_CLR;
        INIT_CLR:  state_d = IDLE;
        IDLE:      if (pio_irq) state_d = RD_REQ;
        RD_REQ:    state_d = RD_WAIT;
        RD_WAIT:   state_d = CLR;
        CLR:       state_d = PUSH;
`ifdef BUTTON_EVENT_CTRL_LOCKOUT_EN
        PUSH:      state_d = LOCKOUT;
        LOCKOUT:   if (lock_cnt_q == '0) state_d = IDLE;
`else
        PUSH:      state_d = IDLE;
        LOCKOUT:   state_d = IDLE;
`endif
        default:   state_d = INIT_MASK;
      endcase
    end
  end

  // Bus outputs are registered from the next state so they track state_q
  // exactly and sit idle while reset is held.
  always_comb begin
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = 2'd0;
    wdata_d = 32'd0;
    case (state_d)
      INIT_MASK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd2; wdata_d = {28'd0, IRQ_MASK};
      end
      INIT_CLR, CLR: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = 2'd3;
      end
      RD_REQ, RD_WAIT: begin
        cs_d = 1'b1; addr_d = 2'd3;
      end
      default: ;
    endcase
  end

  // Capture register and event FIFO with overflow tracking.
  always_comb begin
    cap_d = cap_q;
    if (state_q == RD_WAIT) cap_d = avm_readdata[3:0];

    full    = (count_q == CW'(FIFO_DEPTH));
    pop     = evt_valid & evt_ready;
    in_push = (state_q == PUSH) && (cap_q != 4'd0);
    push    = in_push && (!full || pop);
    drop    = in_push && full && !pop;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = cap_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

`ifdef BUTTON_EVENT_CTRL_LOCKOUT_EN
  // Lockout counter: loaded on PUSH, counts down to zero while in LOCKOUT.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == PUSH)
      lock_cnt_d = LW'(LOCKOUT_CYCLES - 1);
    else if (state_q == LOCKOUT && lock_cnt_q != '0)
      lock_cnt_d = lock_cnt_q - LW'(1);
  end

  // Lockout counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) lock_cnt_q <= '0;
    else          lock_cnt_q <= lock_cnt_d;
  end
`endif

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= INIT_MASK;
      started_q <= 1'b0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      addr_q    <= 2'd0;
      wdata_q   <= 32'd0;
      cap_q     <= 4'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'd0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cap_q     <= cap_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: behavioural pushbutton PIO, expected-event
// queue filled by the stimulus, and a monitor that checks every pop.
module tb_button_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic        pio_irq;
  logic [3:0]  evt_data;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

`ifdef BUTTON_EVENT_CTRL_LOCKOUT_EN
  localparam int LAT2 = 11;
`else
  localparam int LAT2 = 4;
`endif

  always #5 clk = ~clk;

  button_event_ctrl #(.IRQ_MASK(4'hF), .FIFO_DEPTH(4), .LOCKOUT_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .pio_irq(pio_irq),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
  );

  // Pushbutton PIO model: active-low buttons, falling-edge capture,
  // registered reads, clear write has priority over new edges.
  logic [3:0] in_port = 4'hF;
  logic [3:0] in_prev = 4'hF;
  logic [3:0] edge_cap = 4'h0;
  logic [3:0] irq_mask = 4'h0;
  assign pio_irq = |(edge_cap & irq_mask);

  always @(posedge clk) begin
    in_prev <= in_port;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
      edge_cap <= 4'h0;
    else
      edge_cap <= edge_cap | (in_prev & ~in_port);
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
      irq_mask <= avm_writedata[3:0];
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == 2'd3) ? {28'd0, edge_cap} :
                      (avm_address == 2'd2) ? {28'd0, irq_mask} : {28'd0, in_port};
    else
      avm_readdata <= 32'd0;
  end

  // Monitor: every accepted event must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL evt_unexpected: got 0x%0h required none", evt_data);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (evt_data !== e) begin
          n_bad++;
          $display("FAIL evt_data: got 0x%0h required 0x%0h", evt_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Hold reset two edges, release, then check the two init writes.
  task automatic reset_seq();
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_cs", {31'd0, avm_chipselect}, 32'd0);
    chk("rst_wn", {31'd0, avm_write_n}, 32'd1);
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("init1_bus", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b0, 2'd2});
    chk("init1_data", avm_writedata, 32'hF);
    tick();
    chk("init2_bus", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b0, 2'd3});
    chk("init2_data", avm_writedata, 32'h0);
    tick();
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("idle_cs", {31'd0, avm_chipselect}, 32'd0);
  endtask

  task automatic press(input int b, input bit expect_push);
    wait_idle();
    tick();
    in_port[b] = 1'b0;
    if (expect_push) exp_q.push_back(4'(1 << b));
    tick();
    in_port[b] = 1'b1;
    tick();
    wait_idle();
  endtask

  task automatic drain();
    int n = 0;
    evt_ready = 1'b1;
    while (evt_valid && n < 50) begin tick(); n++; end
    chk("drain_valid", {31'd0, evt_valid}, 32'd0);
    chk("drain_left", exp_q.size(), 32'd0);
    evt_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;

    reset_seq();

    // Single press of button 2: latency and irq clear.
    wait_idle();
    evt_ready = 1'b1;
    tick();
    in_port[2] = 1'b0;
    exp_q.push_back(4'b0100);
    tick();
    chk("irq_high", {31'd0, pio_irq}, 32'd1);
    in_port[2] = 1'b1;
    tick();
    lat = 0;
    while (!evt_valid && lat < 30) begin tick(); lat++; end
    chk("latency", lat, 32'd4);
    chk("irq_cleared", {31'd0, pio_irq}, 32'd0);

    // Second edge three cycles after PUSH.
    tick(); tick();
    in_port[1] = 1'b0;
    exp_q.push_back(4'b0010);
    tick();
    in_port[1] = 1'b1;
    tick();
    lat = 0;
    while (!evt_valid && lat < 30) begin tick(); lat++; end
    chk("latency_after_push", lat, LAT2);
    tick();
    wait_idle();
    chk("q_empty1", exp_q.size(), 32'd0);

    // Overflow: four queue, fifth dropped, then clear.
    evt_ready = 1'b0;
    press(0, 1); press(1, 1); press(2, 1); press(3, 1);
    chk("ovf_after4", {31'd0, overflow}, 32'd0);
    press(0, 0);
    chk("ovf_after5", {31'd0, overflow}, 32'd1);
    chk("head_data", {28'd0, evt_data}, 32'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    drain();

    // Full FIFO with a pop during PUSH: push accepted, no overflow.
    press(0, 1); press(1, 1); press(2, 1); press(3, 1);
    tick();
    in_port[2] = 1'b0;
    exp_q.push_back(4'b0100);
    tick();
    in_port[2] = 1'b1;
    tick(); tick(); tick(); tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    wait_idle();
    chk("ovf_full_pop", {31'd0, overflow}, 32'd0);
    chk("q_after_pop", exp_q.size(), 32'd4);
    drain();

    // Reset during RD_WAIT: sequence aborted, no event.
    evt_ready = 1'b1;
    tick();
    in_port[3] = 1'b0;
    tick();
    in_port[3] = 1'b1;
    tick(); tick();
    reset_seq();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (evt_valid || busy) seen = 1'b1;
    end
    chk("no_evt_after_rst", {31'd0, seen}, 32'd0);
    chk("irq_after_rst", {31'd0, pio_irq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
